// File: rtl/rv32i_core.sv
`default_nettype none
// ============================================================================
// Module   : rv32i_core
// Brief    : Single-cycle RV32I integer core with on-chip instruction ROM and
//            byte-addressable data RAM. Exposes the register file and a
//            registered commit port for lock-step comparison.
// Revision : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
// Instruction ROM: asynchronous word read. The write port exists only so the
// array has a driver in the netlist; it is tied off at the core level and the
// contents come from the harness preload.
// ----------------------------------------------------------------------------
module rv32i_rom #(
    parameter int WORDS = 4096
) (
    input  logic        clk,
    input  logic        i_we,
    input  logic [29:0] i_waddr,
    input  logic [31:0] i_wdata,
    input  logic [29:0] i_word,
    output logic [31:0] o_data
);
    localparam int AW = (WORDS > 1) ? $clog2(WORDS) : 1;

    logic [31:0] mem [0:WORDS-1];

    assign o_data = mem[AW'(i_word % 30'(WORDS))];

    // Tied-off write port
    always_ff @(posedge clk) begin
        if (i_we) mem[AW'(i_waddr % 30'(WORDS))] <= i_wdata;
    end
endmodule

// ----------------------------------------------------------------------------
// Data RAM: asynchronous read, synchronous byte-enabled write.
// ----------------------------------------------------------------------------
module rv32i_ram #(
    parameter int WORDS = 4096
) (
    input  logic        clk,
    input  logic [29:0] i_word,
    input  logic [3:0]  i_be,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_rdata
);
    localparam int AW = (WORDS > 1) ? $clog2(WORDS) : 1;

    logic [31:0] mem [0:WORDS-1];

    assign o_rdata = mem[AW'(i_word % 30'(WORDS))];

    // Write only the enabled byte lanes; other lanes keep their contents
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (i_be[b]) mem[AW'(i_word % 30'(WORDS))][8*b +: 8] <= i_wdata[8*b +: 8];
        end
    end
endmodule

// ----------------------------------------------------------------------------
// Load/store unit: lane steering for stores and extraction/extension for loads.
// Low address bits pick the lane inside the addressed word; no alignment trap.
// ----------------------------------------------------------------------------
module rv32i_lsu #(
    parameter int WORDS = 4096
) (
    input  logic        clk,
    input  logic [31:0] i_addr,
    input  logic [2:0]  i_funct3,
    input  logic        i_store,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_rdata
);
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [31:0] w_word;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Store byte enables and replicated write data
    always_comb begin
        w_be    = 4'b0000;
        w_wdata = i_wdata;
        case (i_funct3[1:0])
            2'b00: begin
                w_be    = 4'b0001 << i_addr[1:0];
                w_wdata = {4{i_wdata[7:0]}};
            end
            2'b01: begin
                w_be    = i_addr[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{i_wdata[15:0]}};
            end
            default: w_be = 4'b1111;
        endcase
        if (!i_store) w_be = 4'b0000;
    end

    // Load lane selection and sign/zero extension
    always_comb begin
        case (i_addr[1:0])
            2'b00:   w_byte = w_word[7:0];
            2'b01:   w_byte = w_word[15:8];
            2'b10:   w_byte = w_word[23:16];
            default: w_byte = w_word[31:24];
        endcase
        w_half = i_addr[1] ? w_word[31:16] : w_word[15:0];
        case (i_funct3)
            3'b000:  o_rdata = {{24{w_byte[7]}}, w_byte};
            3'b001:  o_rdata = {{16{w_half[15]}}, w_half};
            3'b100:  o_rdata = {24'd0, w_byte};
            3'b101:  o_rdata = {16'd0, w_half};
            default: o_rdata = w_word;
        endcase
    end

    rv32i_ram #(.WORDS(WORDS)) ram (
        .clk     (clk),
        .i_word  (i_addr[31:2]),
        .i_be    (w_be),
        .i_wdata (w_wdata),
        .o_rdata (w_word)
    );
endmodule

// ----------------------------------------------------------------------------
// Data memory subsystem wrapper (keeps the mem.lsu.ram hierarchy stable).
// ----------------------------------------------------------------------------
module rv32i_dmem #(
    parameter int WORDS = 4096
) (
    input  logic        clk,
    input  logic [31:0] i_addr,
    input  logic [2:0]  i_funct3,
    input  logic        i_store,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_rdata
);
    rv32i_lsu #(.WORDS(WORDS)) lsu (
        .clk      (clk),
        .i_addr   (i_addr),
        .i_funct3 (i_funct3),
        .i_store  (i_store),
        .i_wdata  (i_wdata),
        .o_rdata  (o_rdata)
    );
endmodule

// ----------------------------------------------------------------------------
// Core top
// ----------------------------------------------------------------------------
module rv32i_core #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_WORDS = 4096,
    parameter int          DMEM_WORDS = 4096
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        io_in_start,
    output logic [31:0] io_out_state_intRegState_regState_0,
    output logic [31:0] io_out_state_intRegState_regState_1,
    output logic [31:0] io_out_state_intRegState_regState_2,
    output logic [31:0] io_out_state_intRegState_regState_3,
    output logic [31:0] io_out_state_intRegState_regState_4,
    output logic [31:0] io_out_state_intRegState_regState_5,
    output logic [31:0] io_out_state_intRegState_regState_6,
    output logic [31:0] io_out_state_intRegState_regState_7,
    output logic [31:0] io_out_state_intRegState_regState_8,
    output logic [31:0] io_out_state_intRegState_regState_9,
    output logic [31:0] io_out_state_intRegState_regState_10,
    output logic [31:0] io_out_state_intRegState_regState_11,
    output logic [31:0] io_out_state_intRegState_regState_12,
    output logic [31:0] io_out_state_intRegState_regState_13,
    output logic [31:0] io_out_state_intRegState_regState_14,
    output logic [31:0] io_out_state_intRegState_regState_15,
    output logic [31:0] io_out_state_intRegState_regState_16,
    output logic [31:0] io_out_state_intRegState_regState_17,
    output logic [31:0] io_out_state_intRegState_regState_18,
    output logic [31:0] io_out_state_intRegState_regState_19,
    output logic [31:0] io_out_state_intRegState_regState_20,
    output logic [31:0] io_out_state_intRegState_regState_21,
    output logic [31:0] io_out_state_intRegState_regState_22,
    output logic [31:0] io_out_state_intRegState_regState_23,
    output logic [31:0] io_out_state_intRegState_regState_24,
    output logic [31:0] io_out_state_intRegState_regState_25,
    output logic [31:0] io_out_state_intRegState_regState_26,
    output logic [31:0] io_out_state_intRegState_regState_27,
    output logic [31:0] io_out_state_intRegState_regState_28,
    output logic [31:0] io_out_state_intRegState_regState_29,
    output logic [31:0] io_out_state_intRegState_regState_30,
    output logic [31:0] io_out_state_intRegState_regState_31,
    output logic        io_out_state_instState_commit,
    output logic [31:0] io_out_state_instState_pc,
    output logic [31:0] io_out_state_instState_inst
);
    localparam logic [6:0] c_OP_LUI    = 7'b0110111;
    localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;
    localparam logic [6:0] c_OP_JALR   = 7'b1100111;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_IMM    = 7'b0010011;
    localparam logic [6:0] c_OP_REG    = 7'b0110011;

    logic [31:0] r_pc;
    logic        r_running;
    logic [31:0] r_regs [0:31];
    logic        r_commit;
    logic [31:0] r_commit_pc;
    logic [31:0] r_commit_inst;

    logic [31:0] w_inst;
    logic [6:0]  w_opcode;
    logic [4:0]  w_rd, w_rs1, w_rs2;
    logic [2:0]  w_f3;
    logic [6:0]  w_f7;
    logic [31:0] w_rs1_val, w_rs2_val;
    logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
    logic [31:0] w_mem_addr, w_load_data;
    logic        w_wen, w_store, w_taken;
    logic [31:0] w_wdata, w_next_pc;

    function automatic logic [31:0] f_alu(input logic [2:0] f3, input logic [31:0] a,
                                          input logic [31:0] b, input logic alt);
        case (f3)
            3'b000:  f_alu = alt ? (a - b) : (a + b);
            3'b001:  f_alu = a << b[4:0];
            3'b010:  f_alu = {31'd0, $signed(a) < $signed(b)};
            3'b011:  f_alu = {31'd0, a < b};
            3'b100:  f_alu = a ^ b;
            3'b101:  f_alu = alt ? 32'($signed(a) >>> b[4:0]) : (a >> b[4:0]);
            3'b110:  f_alu = a | b;
            default: f_alu = a & b;
        endcase
    endfunction

    assign w_opcode  = w_inst[6:0];
    assign w_rd      = w_inst[11:7];
    assign w_f3      = w_inst[14:12];
    assign w_rs1     = w_inst[19:15];
    assign w_rs2     = w_inst[24:20];
    assign w_f7      = w_inst[31:25];
    assign w_rs1_val = r_regs[w_rs1];
    assign w_rs2_val = r_regs[w_rs2];

    assign w_imm_i = {{20{w_inst[31]}}, w_inst[31:20]};
    assign w_imm_s = {{20{w_inst[31]}}, w_inst[31:25], w_inst[11:7]};
    assign w_imm_b = {{19{w_inst[31]}}, w_inst[31], w_inst[7], w_inst[30:25], w_inst[11:8], 1'b0};
    assign w_imm_u = {w_inst[31:12], 12'd0};
    assign w_imm_j = {{11{w_inst[31]}}, w_inst[31], w_inst[19:12], w_inst[20], w_inst[30:21], 1'b0};

    assign w_mem_addr = w_rs1_val + ((w_opcode == c_OP_STORE) ? w_imm_s : w_imm_i);

    // Branch condition evaluation
    always_comb begin
        case (w_f3)
            3'b000:  w_taken = (w_rs1_val == w_rs2_val);
            3'b001:  w_taken = (w_rs1_val != w_rs2_val);
            3'b100:  w_taken = ($signed(w_rs1_val) < $signed(w_rs2_val));
            3'b101:  w_taken = ($signed(w_rs1_val) >= $signed(w_rs2_val));
            3'b110:  w_taken = (w_rs1_val < w_rs2_val);
            3'b111:  w_taken = (w_rs1_val >= w_rs2_val);
            default: w_taken = 1'b0;
        endcase
    end

    // Decode/execute: writeback value, store request and next pc
    always_comb begin
        w_wen     = 1'b0;
        w_wdata   = 32'd0;
        w_store   = 1'b0;
        w_next_pc = r_pc + 32'd4;
        case (w_opcode)
            c_OP_LUI: begin
                w_wen   = 1'b1;
                w_wdata = w_imm_u;
            end
            c_OP_AUIPC: begin
                w_wen   = 1'b1;
                w_wdata = r_pc + w_imm_u;
            end
            c_OP_JAL: begin
                w_wen     = 1'b1;
                w_wdata   = r_pc + 32'd4;
                w_next_pc = r_pc + w_imm_j;
            end
            c_OP_JALR: begin
                w_wen     = 1'b1;
                w_wdata   = r_pc + 32'd4;
                w_next_pc = (w_rs1_val + w_imm_i) & ~32'd1;
            end
            c_OP_BRANCH: begin
                if (w_taken) w_next_pc = r_pc + w_imm_b;
            end
            c_OP_LOAD: begin
                if (w_f3 != 3'b011 && w_f3 != 3'b110 && w_f3 != 3'b111) begin
                    w_wen   = 1'b1;
                    w_wdata = w_load_data;
                end
            end
            c_OP_STORE: begin
                w_store = (w_f3[2] == 1'b0) && (w_f3[1:0] != 2'b11);
            end
            c_OP_IMM: begin
                w_wen   = 1'b1;
                w_wdata = f_alu(w_f3, w_rs1_val, w_imm_i, (w_f3 == 3'b101) && w_inst[30]);
            end
            c_OP_REG: begin
                // Only base-ISA funct7 encodings; anything else (e.g. M-ext) is a NOP
                if (w_f7 == 7'd0 || (w_f7 == 7'b0100000 && (w_f3 == 3'b000 || w_f3 == 3'b101))) begin
                    w_wen   = 1'b1;
                    w_wdata = f_alu(w_f3, w_rs1_val, w_rs2_val, w_inst[30]);
                end
            end
            default: ;
        endcase
    end

    rv32i_rom #(.WORDS(IMEM_WORDS)) rom (
        .clk     (clock),
        .i_we    (1'b0),
        .i_waddr (30'd0),
        .i_wdata (32'd0),
        .i_word  (r_pc[31:2]),
        .o_data  (w_inst)
    );

    // Stores are only issued while running and never in a reset cycle
    rv32i_dmem #(.WORDS(DMEM_WORDS)) mem (
        .clk      (clock),
        .i_addr   (w_mem_addr),
        .i_funct3 (w_f3),
        .i_store  (w_store && r_running && !reset),
        .i_wdata  (w_rs2_val),
        .o_rdata  (w_load_data)
    );

    // Architectural state, start latch and registered commit port
    always_ff @(posedge clock) begin
        if (reset) begin
            r_pc          <= RESET_PC;
            r_running     <= 1'b0;
            r_commit      <= 1'b0;
            r_commit_pc   <= 32'd0;
            r_commit_inst <= 32'd0;
            for (int i = 0; i < 32; i++) r_regs[i] <= 32'd0;
        end else if (!r_running) begin
            r_commit <= 1'b0;
            if (io_in_start) r_running <= 1'b1;
        end else begin
            r_pc          <= w_next_pc;
            r_commit      <= 1'b1;
            r_commit_pc   <= r_pc;
            r_commit_inst <= w_inst;
            if (w_wen && w_rd != 5'd0) r_regs[w_rd] <= w_wdata;
        end
    end

    assign io_out_state_instState_commit = r_commit;
    assign io_out_state_instState_pc     = r_commit_pc;
    assign io_out_state_instState_inst   = r_commit_inst;

    assign io_out_state_intRegState_regState_0  = 32'd0;
    assign io_out_state_intRegState_regState_1  = r_regs[1];
    assign io_out_state_intRegState_regState_2  = r_regs[2];
    assign io_out_state_intRegState_regState_3  = r_regs[3];
    assign io_out_state_intRegState_regState_4  = r_regs[4];
    assign io_out_state_intRegState_regState_5  = r_regs[5];
    assign io_out_state_intRegState_regState_6  = r_regs[6];
    assign io_out_state_intRegState_regState_7  = r_regs[7];
    assign io_out_state_intRegState_regState_8  = r_regs[8];
    assign io_out_state_intRegState_regState_9  = r_regs[9];
    assign io_out_state_intRegState_regState_10 = r_regs[10];
    assign io_out_state_intRegState_regState_11 = r_regs[11];
    assign io_out_state_intRegState_regState_12 = r_regs[12];
    assign io_out_state_intRegState_regState_13 = r_regs[13];
    assign io_out_state_intRegState_regState_14 = r_regs[14];
    assign io_out_state_intRegState_regState_15 = r_regs[15];
    assign io_out_state_intRegState_regState_16 = r_regs[16];
    assign io_out_state_intRegState_regState_17 = r_regs[17];
    assign io_out_state_intRegState_regState_18 = r_regs[18];
    assign io_out_state_intRegState_regState_19 = r_regs[19];
    assign io_out_state_intRegState_regState_20 = r_regs[20];
    assign io_out_state_intRegState_regState_21 = r_regs[21];
    assign io_out_state_intRegState_regState_22 = r_regs[22];
    assign io_out_state_intRegState_regState_23 = r_regs[23];
    assign io_out_state_intRegState_regState_24 = r_regs[24];
    assign io_out_state_intRegState_regState_25 = r_regs[25];
    assign io_out_state_intRegState_regState_26 = r_regs[26];
    assign io_out_state_intRegState_regState_27 = r_regs[27];
    assign io_out_state_intRegState_regState_28 = r_regs[28];
    assign io_out_state_intRegState_regState_29 = r_regs[29];
    assign io_out_state_intRegState_regState_30 = r_regs[30];
    assign io_out_state_intRegState_regState_31 = r_regs[31];
endmodule

`default_nettype wire

// File: tb/tb_rv32i_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_rv32i_core
// Brief    : Self-checking bench for rv32i_core. Expected commits are queued
//            as programs are started and compared as the core retires them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rv32i_core;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        io_in_start = 1'b0;
    logic [31:0] regs [0:31];
    logic        commit;
    logic [31:0] commit_pc, commit_inst;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } commit_t;

    commit_t     exp_q[$];
    logic [31:0] rom_img [0:63];
    int          n_checks = 0;
    int          n_fail   = 0;

    always #5 clock = ~clock;

    rv32i_core dut (
        .clock (clock), .reset (reset), .io_in_start (io_in_start),
        .io_out_state_intRegState_regState_0 (regs[0]),   .io_out_state_intRegState_regState_1 (regs[1]),
        .io_out_state_intRegState_regState_2 (regs[2]),   .io_out_state_intRegState_regState_3 (regs[3]),
        .io_out_state_intRegState_regState_4 (regs[4]),   .io_out_state_intRegState_regState_5 (regs[5]),
        .io_out_state_intRegState_regState_6 (regs[6]),   .io_out_state_intRegState_regState_7 (regs[7]),
        .io_out_state_intRegState_regState_8 (regs[8]),   .io_out_state_intRegState_regState_9 (regs[9]),
        .io_out_state_intRegState_regState_10 (regs[10]), .io_out_state_intRegState_regState_11 (regs[11]),
        .io_out_state_intRegState_regState_12 (regs[12]), .io_out_state_intRegState_regState_13 (regs[13]),
        .io_out_state_intRegState_regState_14 (regs[14]), .io_out_state_intRegState_regState_15 (regs[15]),
        .io_out_state_intRegState_regState_16 (regs[16]), .io_out_state_intRegState_regState_17 (regs[17]),
        .io_out_state_intRegState_regState_18 (regs[18]), .io_out_state_intRegState_regState_19 (regs[19]),
        .io_out_state_intRegState_regState_20 (regs[20]), .io_out_state_intRegState_regState_21 (regs[21]),
        .io_out_state_intRegState_regState_22 (regs[22]), .io_out_state_intRegState_regState_23 (regs[23]),
        .io_out_state_intRegState_regState_24 (regs[24]), .io_out_state_intRegState_regState_25 (regs[25]),
        .io_out_state_intRegState_regState_26 (regs[26]), .io_out_state_intRegState_regState_27 (regs[27]),
        .io_out_state_intRegState_regState_28 (regs[28]), .io_out_state_intRegState_regState_29 (regs[29]),
        .io_out_state_intRegState_regState_30 (regs[30]), .io_out_state_intRegState_regState_31 (regs[31]),
        .io_out_state_instState_commit (commit),
        .io_out_state_instState_pc     (commit_pc),
        .io_out_state_instState_inst   (commit_inst)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    // Instruction encoders
    function automatic logic [31:0] enc_i(input logic [31:0] imm, input logic [31:0] rs1,
                                          input logic [31:0] f3, input logic [31:0] rd,
                                          input logic [6:0] op);
        return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op};
    endfunction
    function automatic logic [31:0] enc_r(input logic [31:0] f7, input logic [31:0] rs2,
                                          input logic [31:0] rs1, input logic [31:0] f3,
                                          input logic [31:0] rd);
        return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'h33};
    endfunction
    function automatic logic [31:0] enc_s(input logic [31:0] imm, input logic [31:0] rs2,
                                          input logic [31:0] rs1, input logic [31:0] f3);
        return {imm[11:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:0], 7'h23};
    endfunction
    function automatic logic [31:0] enc_b(input logic [31:0] imm, input logic [31:0] rs2,
                                          input logic [31:0] rs1, input logic [31:0] f3);
        return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:1], imm[11], 7'h63};
    endfunction
    function automatic logic [31:0] enc_u(input logic [31:0] imm20, input logic [31:0] rd,
                                          input logic [6:0] op);
        return {imm20[19:0], rd[4:0], op};
    endfunction
    function automatic logic [31:0] enc_j(input logic [31:0] imm, input logic [31:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'h6F};
    endfunction

    task automatic rom_w(input int idx, input logic [31:0] v);
        rom_img[idx] = v;
        dut.rom.mem[idx] <= v;
    endtask
    task automatic rom_clear();
        for (int i = 0; i < 64; i++) rom_w(i, 32'h0000_0013);
    endtask
    task automatic ram_w(input int idx, input logic [31:0] v);
        dut.mem.lsu.ram.mem[idx] <= v;
    endtask
    function automatic logic [31:0] ram_r(input int idx);
        return dut.mem.lsu.ram.mem[idx];
    endfunction

    task automatic expect_pc(input logic [31:0] pc);
        commit_t e;
        e.pc   = pc;
        e.inst = rom_img[pc[7:2]];
        exp_q.push_back(e);
    endtask

    // Holds reset across one rising edge and leaves it asserted
    task automatic enter_reset();
        reset = 1'b1;
        io_in_start = 1'b0;
        @(negedge clock); #1;
        rom_clear();
    endtask
    task automatic start_core();
        io_in_start = 1'b1;
        @(negedge clock); #1;
        io_in_start = 1'b0;
    endtask
    task automatic run(input int n);
        repeat (n) @(negedge clock);
        #1;
    endtask
    task automatic chk_drain(input string tag);
        chk(tag, 32'(exp_q.size()), 32'd0);
    endtask

    // Commit scoreboard
    always @(negedge clock) begin : mon
        commit_t e;
        if (commit === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_commit", {31'd0, commit}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("commit_pc", commit_pc, e.pc);
                chk("commit_inst", commit_inst, e.inst);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Idle without start: nothing commits or writes
        enter_reset();
        rom_w(0, enc_s(8, 0, 0, 2));
        ram_w(2, 32'hDEAD_BEEF);
        reset = 1'b0;
        repeat (10) begin
            @(negedge clock);
            chk("idle_commit", {31'd0, commit}, 32'd0);
        end
        #1;
        for (int i = 0; i < 32; i++) chk($sformatf("idle_x%0d", i), regs[i], 32'd0);
        chk("idle_ram2", ram_r(2), 32'hDEAD_BEEF);

        // Basic arithmetic
        enter_reset();
        rom_w(0, enc_i(5, 0, 0, 1, 7'h13));
        rom_w(1, enc_i(-7, 1, 0, 2, 7'h13));
        rom_w(2, enc_r(0, 2, 1, 0, 3));
        reset = 1'b0;
        start_core();
        expect_pc(0); expect_pc(4); expect_pc(8);
        run(3);
        chk("add_x1", regs[1], 32'd5);
        chk("add_x2", regs[2], 32'hFFFF_FFFE);
        chk("add_x3", regs[3], 32'd3);
        chk_drain("add_drain");

        // LUI / SW / LB / LHU
        enter_reset();
        rom_w(0, enc_u(32'h12345, 5, 7'h37));
        rom_w(1, enc_s(8, 5, 0, 2));
        rom_w(2, enc_i(9, 0, 0, 6, 7'h03));
        rom_w(3, enc_i(10, 0, 5, 7, 7'h03));
        reset = 1'b0;
        start_core();
        for (int i = 0; i < 4; i++) expect_pc(32'(4 * i));
        run(4);
        chk("ls_ram2", ram_r(2), 32'h1234_5000);
        chk("ls_x5", regs[5], 32'h1234_5000);
        chk("ls_x6_lb", regs[6], 32'h0000_0050);
        chk("ls_x7_lhu", regs[7], 32'h0000_1234);
        chk_drain("ls_drain");

        // Byte store into upper lane, signed/unsigned byte reload
        enter_reset();
        ram_w(4, 32'h1122_3344);
        rom_w(0, enc_i(32'hAB, 0, 0, 1, 7'h13));
        rom_w(1, enc_s(32'h13, 1, 0, 0));
        rom_w(2, enc_i(32'h13, 0, 0, 9, 7'h03));
        rom_w(3, enc_i(32'h13, 0, 4, 10, 7'h03));
        reset = 1'b0;
        start_core();
        for (int i = 0; i < 4; i++) expect_pc(32'(4 * i));
        run(4);
        chk("sb_ram4", ram_r(4), 32'hAB22_3344);
        chk("sb_x9_lb", regs[9], 32'hFFFF_FFAB);
        chk("sb_x10_lbu", regs[10], 32'h0000_00AB);
        chk_drain("sb_drain");

        // Branch, forward/backward JAL, write to x0
        enter_reset();
        rom_w(0, enc_i(1, 0, 0, 1, 7'h13));
        rom_w(1, enc_b(12, 1, 0, 1));
        rom_w(2, enc_i(99, 0, 0, 5, 7'h13));
        rom_w(3, enc_i(99, 0, 0, 5, 7'h13));
        rom_w(4, enc_j(16, 0));
        rom_w(6, enc_i(4, 0, 0, 4, 7'h13));
        rom_w(7, enc_i(7, 0, 0, 0, 7'h13));
        rom_w(8, enc_j(-8, 1));
        reset = 1'b0;
        start_core();
        expect_pc(32'h00); expect_pc(32'h04); expect_pc(32'h10);
        expect_pc(32'h20); expect_pc(32'h18); expect_pc(32'h1C);
        run(6);
        chk("br_x1_link", regs[1], 32'h0000_0024);
        chk("br_x4", regs[4], 32'd4);
        chk("br_x5_skipped", regs[5], 32'd0);
        chk("br_x0", regs[0], 32'd0);
        chk_drain("br_drain");

        // Shifts, compares, SUB, AUIPC, XOR, SLL
        enter_reset();
        rom_w(0, enc_i(-16, 0, 0, 1, 7'h13));
        rom_w(1, enc_i(32'h402, 1, 5, 2, 7'h13));
        rom_w(2, enc_i(28, 1, 5, 3, 7'h13));
        rom_w(3, enc_r(0, 0, 1, 2, 4));
        rom_w(4, enc_r(0, 0, 1, 3, 5));
        rom_w(5, enc_r(32'h20, 1, 0, 0, 6));
        rom_w(6, enc_u(1, 7, 7'h17));
        rom_w(7, enc_r(0, 6, 1, 4, 8));
        rom_w(8, enc_r(0, 6, 6, 1, 9));
        reset = 1'b0;
        start_core();
        for (int i = 0; i < 9; i++) expect_pc(32'(4 * i));
        run(9);
        chk("alu_srai", regs[2], 32'hFFFF_FFFC);
        chk("alu_srli", regs[3], 32'h0000_000F);
        chk("alu_slt", regs[4], 32'd1);
        chk("alu_sltu", regs[5], 32'd0);
        chk("alu_sub", regs[6], 32'd16);
        chk("alu_auipc", regs[7], 32'h0000_1018);
        chk("alu_xor", regs[8], 32'hFFFF_FFE0);
        chk("alu_sll", regs[9], 32'h0010_0000);
        chk_drain("alu_drain");

        // Reset mid-program: store in the reset cycle is dropped, restart needs start
        enter_reset();
        ram_w(0, 32'h55AA_55AA);
        rom_w(0, enc_i(5, 0, 0, 1, 7'h13));
        rom_w(1, enc_i(-7, 1, 0, 2, 7'h13));
        rom_w(2, enc_s(0, 1, 0, 2));
        reset = 1'b0;
        start_core();
        expect_pc(0); expect_pc(4);
        run(2);
        chk("mid_x1_before", regs[1], 32'd5);
        reset = 1'b1;
        @(negedge clock); #1;
        reset = 1'b0;
        chk("mid_commit", {31'd0, commit}, 32'd0);
        chk("mid_x1", regs[1], 32'd0);
        chk("mid_x2", regs[2], 32'd0);
        chk("mid_ram0", ram_r(0), 32'h55AA_55AA);
        chk_drain("mid_drain");
        repeat (3) begin
            @(negedge clock);
            chk("mid_idle_commit", {31'd0, commit}, 32'd0);
        end
        #1;
        start_core();
        expect_pc(0); expect_pc(4); expect_pc(8);
        run(3);
        chk("re_x2", regs[2], 32'hFFFF_FFFE);
        chk("re_ram0", ram_r(0), 32'd5);
        chk_drain("re_drain");

        reset = 1'b1;
        run(2);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/rv32i_core.md
Name: rv32i_core

Overview:
- Single-cycle RV32I integer core with on-chip instruction ROM and data RAM.
- After start, fetches and executes one instruction per clock.
- Exposes the full integer register file and per-instruction commit info (commit/pc/inst) for lock-step comparison against a reference model in simulation.
- Top-level CPU block of the design; the test harness preloads both memories through hierarchical paths.

Parameters:
- RESET_PC, 32'h0000_0000, PC value after reset.
- IMEM_WORDS, 4096, instruction ROM depth in 32-bit words.
- DMEM_WORDS, 4096, data RAM depth in 32-bit words.

Ports:
- clock  input  1  single system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- io_in_start  input  1  start request; the core stays idle until sampled high.
- io_out_state_intRegState_regState_0 .. _31  output  32 each  current contents of x0..x31.
- io_out_state_instState_commit  output  1  high for one cycle per retired instruction.
- io_out_state_instState_pc  output  32  PC of the retired instruction.
- io_out_state_instState_inst  output  32  encoding of the retired instruction.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high.
- Reset state:
  - pc=RESET_PC, running=0, all 32 registers=0.
  - commit=0, commit pc=0, commit inst=0.
  - Memory contents are NOT cleared by reset.
- Start:
  - running is set on the first edge where io_in_start=1 and reset=0.
  - running stays set until reset; start is ignored afterwards.
  - While not running: no fetch, no architectural update, commit=0.
- Memory hierarchy (required for harness preload):
  - Instance "rom" holds instruction array "mem".
  - Instance "mem" contains instance "lsu", which contains instance "ram" with array "mem".
  - Both arrays are [0:N-1] of 32-bit words, loaded via $readmemh.
- Instruction ROM: asynchronous read; word index = pc[31:2] modulo IMEM_WORDS.
- Data RAM:
  - Asynchronous read; synchronous write at the clock edge.
  - Word index = addr[31:2] modulo DMEM_WORDS.
- Execution: each running cycle executes the instruction at pc. Register write and pc update occur at the same edge. x0 always reads 0 and writes to it are discarded.
- Supported instructions:
  - LUI, AUIPC, JAL, JALR (target LSB cleared).
  - BEQ/BNE/BLT/BGE/BLTU/BGEU.
  - LB/LH/LW/LBU/LHU, SB/SH/SW.
  - ADDI/SLTI/SLTIU/XORI/ORI/ANDI/SLLI/SRLI/SRAI.
  - ADD/SUB/SLL/SLT/SLTU/XOR/OR/AND/SRL/SRA.
- Arithmetic: 32-bit, wrap-around on overflow. Shift amount is rs2[4:0] or imm[4:0]. SRA/SRAI are arithmetic; SLT is signed, SLTU unsigned.
- Next pc: pc+4 by default; branch/jump target when taken.
- Loads: byte lane = addr[1:0]; halfword lane = addr[1]. Sign- or zero-extend per funct3. Misalignment is not trapped; low address bits select the lane within the addressed word.
- Stores: byte enables derived from funct3 and addr[1:0]; unselected bytes of the word are preserved.
- FENCE, ECALL, EBREAK, SYSTEM/CSR and any unrecognised opcode: executed as NOP (pc+4, no writes) and still committed.
- Commit port:
  - Registered. At the edge that retires instruction I: commit<=1, pc<=I.pc, inst<=I.encoding.
  - In that same cycle, regState already reflects I's writeback.
  - commit<=0 on any non-running cycle.
- regState outputs are driven directly from the register array; regState_0 is constant 0.
- Reset asserted mid-run:
  - Next edge returns to the reset state (running=0, pc=RESET_PC).
  - A store in the reset cycle is suppressed.

Test Plan:
- Reset then hold io_in_start=0 for 10 cycles -> commit stays 0, all regState=0, no RAM writes.
- ROM[0]=addi x1,x0,5; ROM[1]=addi x2,x1,-7; ROM[2]=add x3,x1,x2; start=1 -> commits with pc 0,4,8 on consecutive cycles; then x1=5, x2=0xFFFFFFFE, x3=3.
- ROM[0]=lui x5,0x12345; ROM[1]=sw x5,8(x0); ROM[2]=lb x6,9(x0); ROM[3]=lhu x7,10(x0) -> RAM word 2=0x12345000, x6=0x00000050, x7=0x00001234.
- sb of 0xAB to addr 0x13 over word 4 preloaded 0x11223344 -> word 4=0xAB223344.
- bne x0,x1,+12 with x1=1 -> next commit pc=branch pc+12; jal x1,-8 at pc 0x20 -> x1=0x24, next commit pc=0x18.
- addi x0,x0,7 -> x0 stays 0, commit still pulses.
- Assert reset for one cycle mid-program -> next cycle commit=0, all regs 0, pc restarts at 0 only after a new start.
